// File: rtl/rs_tag_alloc_if.sv
// Handshake bundle between dispatch / RS-CDB logic and the tag allocator.
// Channel c occupies bits [c*TAG_W +: TAG_W] of the tag vectors and
// [c*(TAG_W+1) +: TAG_W+1] of used_cnt.
interface rs_tag_alloc_if #(
    parameter int CHANNELS = 2,
    parameter int TAG_W    = 3
);
    logic                          flush;
    logic [CHANNELS-1:0]           alloc_req;
    logic [CHANNELS-1:0]           free_valid;
    logic [CHANNELS*TAG_W-1:0]     free_tag;
    logic [CHANNELS-1:0]           rel_valid;
    logic [CHANNELS*TAG_W-1:0]     rel_tag;
    logic [CHANNELS*(TAG_W+1)-1:0] used_cnt;
    logic [CHANNELS-1:0]           full;
    logic [CHANNELS-1:0]           empty;
    logic [CHANNELS-1:0]           err;

    modport master (
        output flush, alloc_req, rel_valid, rel_tag,
        input  free_valid, free_tag, used_cnt, full, empty, err
    );

    modport slave (
        input  flush, alloc_req, rel_valid, rel_tag,
        output free_valid, free_tag, used_cnt, full, empty, err
    );
endinterface

// File: rtl/rs_tag_alloc.sv
// Free-tag allocator for the reservation stations. Each channel owns a
// registered busy bitmap, a round-robin pointer, an occupancy count and a
// sticky error flag. The offered tag depends only on registered state, so
// no request input reaches an output combinationally.
module rs_tag_alloc #(
    parameter int ENTRIES  = 8,
    parameter int TAG_W    = 3,
    parameter int CHANNELS = 2,
    parameter int POLICY   = 0
) (
    input  logic          clk,
    input  logic          rst,
    rs_tag_alloc_if.slave bus
);
    localparam int CW = TAG_W + 1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ENTRIES-1:0] busy_q, busy_d;
        logic [TAG_W-1:0]   ptr_q, ptr_d;
        logic [CW-1:0]      cnt_q, cnt_d;
        logic               err_q, err_d;

        logic               pick_valid;
        logic [TAG_W-1:0]   pick_tag;
        logic [TAG_W-1:0]   rtag;
        logic [ENTRIES-1:0] alloc_mask, rel_mask;
        logic               alloc_ok, alloc_bad, rel_ok, rel_bad;

        assign rtag = bus.rel_tag[c*TAG_W +: TAG_W];

        // Pick the free entry to offer. The scan runs from the far end so the
        // last hit, i.e. the first in priority order, wins.
        always_comb begin
            int idx;
            pick_valid = 1'b0;
            pick_tag   = '0;
            idx        = 0;
            for (int k = ENTRIES - 1; k >= 0; k--) begin
                if (POLICY == 1) begin
                    idx = int'(ptr_q) + k;
                    if (idx >= ENTRIES) idx = idx - ENTRIES;
                end else begin
                    idx = k;
                end
                if (!busy_q[idx]) begin
                    pick_valid = 1'b1;
                    pick_tag   = TAG_W'(idx);
                end
            end
        end

        // One-hot masks for the offered tag and the release tag; an
        // out-of-range release tag yields an all-zero mask.
        always_comb begin
            alloc_mask = '0;
            rel_mask   = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                alloc_mask[i] = (int'(pick_tag) == i);
                rel_mask[i]   = (int'(rtag) == i);
            end
        end

        assign alloc_ok  = bus.alloc_req[c] & pick_valid;
        assign alloc_bad = bus.alloc_req[c] & ~pick_valid;
        assign rel_ok    = bus.rel_valid[c] & (|(busy_q & rel_mask));
        assign rel_bad   = bus.rel_valid[c] & ~rel_ok;

        // Next-state: flush wins over everything but leaves err alone; a legal
        // alloc and release in the same cycle cannot hit the same entry.
        always_comb begin
            busy_d = busy_q;
            ptr_d  = ptr_q;
            cnt_d  = cnt_q;
            err_d  = err_q;
            if (bus.flush) begin
                busy_d = '0;
                ptr_d  = '0;
                cnt_d  = '0;
            end else begin
                err_d = err_q | alloc_bad | rel_bad;
                if (alloc_ok) begin
                    busy_d = busy_d | alloc_mask;
                    if (int'(pick_tag) == ENTRIES - 1) ptr_d = '0;
                    else                               ptr_d = pick_tag + TAG_W'(1);
                end
                if (rel_ok) busy_d = busy_d & ~rel_mask;
                case ({alloc_ok, rel_ok})
                    2'b10:   cnt_d = cnt_q + CW'(1);
                    2'b01:   cnt_d = cnt_q - CW'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                busy_q <= '0;
                ptr_q  <= '0;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else begin
                busy_q <= busy_d;
                ptr_q  <= ptr_d;
                cnt_q  <= cnt_d;
                err_q  <= err_d;
            end
        end

        assign bus.free_valid[c]              = pick_valid;
        assign bus.free_tag[c*TAG_W +: TAG_W] = pick_tag;
        assign bus.used_cnt[c*CW +: CW]       = cnt_q;
        assign bus.full[c]                    = (int'(cnt_q) == ENTRIES);
        assign bus.empty[c]                   = (cnt_q == '0);
        assign bus.err[c]                     = err_q;
    end
endmodule

// File: tb/tb_rs_tag_alloc.sv
// Directed bench for rs_tag_alloc: one instance per selection policy.
module tb_rs_tag_alloc;
    localparam int EN = 8;
    localparam int TW = 3;
    localparam int CH = 2;

    logic clk;
    logic rst;
    int   vec;
    int   miscompares;

    rs_tag_alloc_if #(.CHANNELS(CH), .TAG_W(TW)) if_p0 ();
    rs_tag_alloc_if #(.CHANNELS(CH), .TAG_W(TW)) if_p1 ();

    rs_tag_alloc #(.ENTRIES(EN), .TAG_W(TW), .CHANNELS(CH), .POLICY(0)) u_p0 (
        .clk (clk),
        .rst (rst),
        .bus (if_p0.slave)
    );

    rs_tag_alloc #(.ENTRIES(EN), .TAG_W(TW), .CHANNELS(CH), .POLICY(1)) u_p1 (
        .clk (clk),
        .rst (rst),
        .bus (if_p1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TW-1:0] tag_of(input logic [CH*TW-1:0] v, input int c);
        return v[c*TW +: TW];
    endfunction

    function automatic logic [TW:0] cnt_of(input logic [CH*(TW+1)-1:0] v, input int c);
        return v[c*(TW+1) +: TW+1];
    endfunction

    task automatic idle_inputs();
        if_p0.flush = 1'b0; if_p0.alloc_req = '0; if_p0.rel_valid = '0; if_p0.rel_tag = '0;
        if_p1.flush = 1'b0; if_p1.alloc_req = '0; if_p1.rel_valid = '0; if_p1.rel_tag = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec++; if (if_p0.free_valid !== 2'b11) begin miscompares++; $display("FAIL reset_p0_free_valid got=%b exp=11", if_p0.free_valid); end
        vec++; if (if_p0.free_tag !== 6'd0) begin miscompares++; $display("FAIL reset_p0_free_tag got=%h exp=0", if_p0.free_tag); end
        vec++; if (if_p0.used_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_p0_used_cnt got=%h exp=0", if_p0.used_cnt); end
        vec++; if (if_p0.empty !== 2'b11) begin miscompares++; $display("FAIL reset_p0_empty got=%b exp=11", if_p0.empty); end
        vec++; if (if_p0.full !== 2'b00) begin miscompares++; $display("FAIL reset_p0_full got=%b exp=00", if_p0.full); end
        vec++; if (if_p0.err !== 2'b00) begin miscompares++; $display("FAIL reset_p0_err got=%b exp=00", if_p0.err); end
        vec++; if (if_p1.free_valid !== 2'b11 || if_p1.free_tag !== 6'd0 || if_p1.used_cnt !== 8'd0)
            begin miscompares++; $display("FAIL reset_p1_state got fv=%b tag=%h cnt=%h exp fv=11 tag=0 cnt=0", if_p1.free_valid, if_p1.free_tag, if_p1.used_cnt); end
    endtask

    task automatic test_lowest_fill();
        for (int i = 0; i < EN; i++) begin
            vec++; if (tag_of(if_p0.free_tag, 0) !== TW'(i) || if_p0.free_valid[0] !== 1'b1)
                begin miscompares++; $display("FAIL fill_tag step=%0d got tag=%0d fv=%b exp tag=%0d fv=1", i, tag_of(if_p0.free_tag, 0), if_p0.free_valid[0], i); end
            if_p0.alloc_req = 2'b01;
            @(negedge clk);
        end
        if_p0.alloc_req = 2'b00;
        vec++; if (if_p0.full[0] !== 1'b1) begin miscompares++; $display("FAIL fill_full got=%b exp=1", if_p0.full[0]); end
        vec++; if (if_p0.free_valid[0] !== 1'b0) begin miscompares++; $display("FAIL fill_free_valid got=%b exp=0", if_p0.free_valid[0]); end
        vec++; if (cnt_of(if_p0.used_cnt, 0) !== 4'd8) begin miscompares++; $display("FAIL fill_cnt got=%0d exp=8", cnt_of(if_p0.used_cnt, 0)); end
        vec++; if (tag_of(if_p0.free_tag, 0) !== 3'd0) begin miscompares++; $display("FAIL fill_tag_when_full got=%0d exp=0", tag_of(if_p0.free_tag, 0)); end
        vec++; if (tag_of(if_p0.free_tag, 1) !== 3'd0 || cnt_of(if_p0.used_cnt, 1) !== 4'd0 || if_p0.empty[1] !== 1'b1)
            begin miscompares++; $display("FAIL fill_ch1_idle got tag=%0d cnt=%0d empty=%b exp 0 0 1", tag_of(if_p0.free_tag, 1), cnt_of(if_p0.used_cnt, 1), if_p0.empty[1]); end
    endtask

    task automatic test_release_and_alloc();
        if_p0.rel_valid = 2'b01; if_p0.rel_tag = 6'd3;
        @(negedge clk);
        if_p0.rel_valid = 2'b00;
        vec++; if (tag_of(if_p0.free_tag, 0) !== 3'd3 || if_p0.free_valid[0] !== 1'b1)
            begin miscompares++; $display("FAIL rel3_tag got=%0d fv=%b exp=3 fv=1", tag_of(if_p0.free_tag, 0), if_p0.free_valid[0]); end
        vec++; if (cnt_of(if_p0.used_cnt, 0) !== 4'd7) begin miscompares++; $display("FAIL rel3_cnt got=%0d exp=7", cnt_of(if_p0.used_cnt, 0)); end
        // alloc takes 3 while 5 is released: busy becomes 0xDF
        if_p0.alloc_req = 2'b01; if_p0.rel_valid = 2'b01; if_p0.rel_tag = 6'd5;
        @(negedge clk);
        if_p0.alloc_req = 2'b00; if_p0.rel_valid = 2'b00;
        vec++; if (cnt_of(if_p0.used_cnt, 0) !== 4'd7) begin miscompares++; $display("FAIL simul_cnt got=%0d exp=7", cnt_of(if_p0.used_cnt, 0)); end
        vec++; if (tag_of(if_p0.free_tag, 0) !== 3'd5) begin miscompares++; $display("FAIL simul_tag got=%0d exp=5", tag_of(if_p0.free_tag, 0)); end
        vec++; if (if_p0.err !== 2'b00) begin miscompares++; $display("FAIL simul_err got=%b exp=00", if_p0.err); end
        if_p0.alloc_req = 2'b01;
        @(negedge clk);
        if_p0.alloc_req = 2'b00;
        vec++; if (if_p0.full[0] !== 1'b1 || cnt_of(if_p0.used_cnt, 0) !== 4'd8)
            begin miscompares++; $display("FAIL refill_full got full=%b cnt=%0d exp full=1 cnt=8", if_p0.full[0], cnt_of(if_p0.used_cnt, 0)); end
    endtask

    task automatic test_round_robin();
        logic [TW-1:0] exp_seq [6];
        exp_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 2; i++) begin
            vec++; if (tag_of(if_p1.free_tag, 0) !== TW'(i))
                begin miscompares++; $display("FAIL rr_first_tag step=%0d got=%0d exp=%0d", i, tag_of(if_p1.free_tag, 0), i); end
            if_p1.alloc_req = 2'b01;
            @(negedge clk);
        end
        if_p1.alloc_req = 2'b00;
        if_p1.rel_valid = 2'b01; if_p1.rel_tag = 6'd0;
        @(negedge clk);
        if_p1.rel_valid = 2'b00;
        vec++; if (tag_of(if_p1.free_tag, 0) !== 3'd2 || cnt_of(if_p1.used_cnt, 0) !== 4'd1)
            begin miscompares++; $display("FAIL rr_after_rel got tag=%0d cnt=%0d exp tag=2 cnt=1", tag_of(if_p1.free_tag, 0), cnt_of(if_p1.used_cnt, 0)); end
        for (int i = 0; i < 6; i++) begin
            vec++; if (tag_of(if_p1.free_tag, 0) !== exp_seq[i])
                begin miscompares++; $display("FAIL rr_seq step=%0d got=%0d exp=%0d", i, tag_of(if_p1.free_tag, 0), exp_seq[i]); end
            if_p1.alloc_req = 2'b01;
            @(negedge clk);
        end
        if_p1.alloc_req = 2'b00;
        vec++; if (tag_of(if_p1.free_tag, 0) !== 3'd0 || if_p1.free_valid[0] !== 1'b1)
            begin miscompares++; $display("FAIL rr_wrap got tag=%0d fv=%b exp tag=0 fv=1", tag_of(if_p1.free_tag, 0), if_p1.free_valid[0]); end
        if_p1.alloc_req = 2'b01;
        @(negedge clk);
        vec++; if (if_p1.full[0] !== 1'b1 || if_p1.err[0] !== 1'b0)
            begin miscompares++; $display("FAIL rr_full got full=%b err=%b exp full=1 err=0", if_p1.full[0], if_p1.err[0]); end
        @(negedge clk);
        if_p1.alloc_req = 2'b00;
        vec++; if (if_p1.err !== 2'b01) begin miscompares++; $display("FAIL rr_overalloc_err got=%b exp=01", if_p1.err); end
        vec++; if (cnt_of(if_p1.used_cnt, 0) !== 4'd8 || if_p1.full[0] !== 1'b1 || if_p1.free_valid[0] !== 1'b0)
            begin miscompares++; $display("FAIL rr_overalloc_state got cnt=%0d full=%b fv=%b exp 8 1 0", cnt_of(if_p1.used_cnt, 0), if_p1.full[0], if_p1.free_valid[0]); end
    endtask

    task automatic test_bad_release();
        if_p0.rel_valid = 2'b10; if_p0.rel_tag = {3'd4, 3'd0};
        @(negedge clk);
        if_p0.rel_valid = 2'b00;
        vec++; if (if_p0.err !== 2'b10) begin miscompares++; $display("FAIL badrel_err got=%b exp=10", if_p0.err); end
        vec++; if (cnt_of(if_p0.used_cnt, 1) !== 4'd0 || cnt_of(if_p0.used_cnt, 0) !== 4'd8)
            begin miscompares++; $display("FAIL badrel_cnt got ch0=%0d ch1=%0d exp 8 0", cnt_of(if_p0.used_cnt, 0), cnt_of(if_p0.used_cnt, 1)); end
        if_p0.flush = 1'b1;
        @(negedge clk);
        if_p0.flush = 1'b0;
        vec++; if (if_p0.err !== 2'b10) begin miscompares++; $display("FAIL flush_keeps_err got=%b exp=10", if_p0.err); end
        vec++; if (if_p0.used_cnt !== 8'd0 || if_p0.empty !== 2'b11)
            begin miscompares++; $display("FAIL flush_clears got cnt=%h empty=%b exp cnt=0 empty=11", if_p0.used_cnt, if_p0.empty); end
    endtask

    task automatic test_flush_override();
        if_p0.alloc_req = 2'b01;
        repeat (5) @(negedge clk);
        if_p0.alloc_req = 2'b00;
        vec++; if (cnt_of(if_p0.used_cnt, 0) !== 4'd5 || tag_of(if_p0.free_tag, 0) !== 3'd5)
            begin miscompares++; $display("FAIL pre_flush got cnt=%0d tag=%0d exp cnt=5 tag=5", cnt_of(if_p0.used_cnt, 0), tag_of(if_p0.free_tag, 0)); end
        // rel_tag 6 on ch0 is not busy and ch1 releases on an empty pool;
        // both would be errors without the flush override.
        if_p0.flush = 1'b1; if_p0.alloc_req = 2'b11; if_p0.rel_valid = 2'b11; if_p0.rel_tag = {3'd1, 3'd6};
        @(negedge clk);
        idle_inputs();
        vec++; if (if_p0.used_cnt !== 8'd0) begin miscompares++; $display("FAIL flush_ovr_cnt got=%h exp=0", if_p0.used_cnt); end
        vec++; if (if_p0.free_tag !== 6'd0 || if_p0.free_valid !== 2'b11)
            begin miscompares++; $display("FAIL flush_ovr_tag got tag=%h fv=%b exp tag=0 fv=11", if_p0.free_tag, if_p0.free_valid); end
        vec++; if (if_p0.err !== 2'b10) begin miscompares++; $display("FAIL flush_ovr_err got=%b exp=10", if_p0.err); end
    endtask

    task automatic test_async_reset();
        if_p0.alloc_req = 2'b11;
        if_p1.alloc_req = 2'b10;
        repeat (2) @(negedge clk);
        vec++; if (cnt_of(if_p0.used_cnt, 0) !== 4'd2 || cnt_of(if_p0.used_cnt, 1) !== 4'd2)
            begin miscompares++; $display("FAIL burst_cnt got ch0=%0d ch1=%0d exp 2 2", cnt_of(if_p0.used_cnt, 0), cnt_of(if_p0.used_cnt, 1)); end
        #2 rst = 1'b1;
        #1;
        vec++; if (if_p0.used_cnt !== 8'd0 || if_p0.free_tag !== 6'd0 || if_p0.free_valid !== 2'b11)
            begin miscompares++; $display("FAIL async_rst_p0 got cnt=%h tag=%h fv=%b exp 0 0 11", if_p0.used_cnt, if_p0.free_tag, if_p0.free_valid); end
        vec++; if (if_p0.err !== 2'b00 || if_p1.err !== 2'b00)
            begin miscompares++; $display("FAIL async_rst_err got p0=%b p1=%b exp 00 00", if_p0.err, if_p1.err); end
        vec++; if (if_p1.used_cnt !== 8'd0 || if_p1.empty !== 2'b11 || if_p1.full !== 2'b00)
            begin miscompares++; $display("FAIL async_rst_p1 got cnt=%h empty=%b full=%b exp 0 11 00", if_p1.used_cnt, if_p1.empty, if_p1.full); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec++; if (if_p0.used_cnt !== 8'd0 || if_p1.free_tag !== 6'd0)
            begin miscompares++; $display("FAIL post_rst got p0cnt=%h p1tag=%h exp 0 0", if_p0.used_cnt, if_p1.free_tag); end
    endtask

    initial begin
        vec = 0;
        miscompares = 0;
        test_reset();
        test_lowest_fill();
        test_release_and_alloc();
        test_round_robin();
        test_bad_release();
        test_flush_override();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end
endmodule
